// File: rtl/hd_burst_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : hd_burst_tx_if
//  Description : Command handshake plus valid/ready beat channel of
//                hd_burst_tx. stall_cnt exists only with
//                HD_BURST_TX_STALL_CNT_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface hd_burst_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  ready;
    logic                  valid_output;
    logic [DATA_WIDTH-1:0] data_dest;
    logic                  last_output;
    logic                  done;
    logic                  busy;
`ifdef HD_BURST_TX_STALL_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    // master: the burst transmitter itself
    modport master (
        input  cmd_valid,
        input  cmd_base,
        input  cmd_len,
        input  ready,
        output cmd_ready,
        output valid_output,
        output data_dest,
        output last_output,
        output done,
`ifdef HD_BURST_TX_STALL_CNT_EN
        output stall_cnt,
`endif
        output busy
    );

    // slave: command issuer and beat consumer
    modport slave (
        output cmd_valid,
        output cmd_base,
        output cmd_len,
        output ready,
        input  cmd_ready,
        input  valid_output,
        input  data_dest,
        input  last_output,
        input  done,
`ifdef HD_BURST_TX_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/hd_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module      : hd_burst_tx
//  Description : Burst stream source; emits cmd_len beats cmd_base, +STEP, ...
//                on a valid/ready channel, then pulses done for one cycle.
//                Optional stall counter: define HD_BURST_TX_STALL_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module hd_burst_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int STEP       = 1
) (
    input  wire             clk,
    input  wire             rst_n,
    hd_burst_tx_if.master   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] c_STEP     = DATA_WIDTH'(STEP);
    localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  c_LEN_TWO  = LEN_WIDTH'(2);

    logic [1:0]            r_state;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data;
    logic [LEN_WIDTH-1:0]  r_remaining;

    logic                  w_accept;
    logic                  w_xfer;

    assign w_accept = bus.cmd_valid && (r_state == c_IDLE);
    assign w_xfer   = r_valid && bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (bus.cmd_len != '0) begin
                            r_state     <= c_SEND;
                            r_valid     <= 1'b1;
                            r_data      <= bus.cmd_base;
                            r_remaining <= bus.cmd_len;
                            r_last      <= (bus.cmd_len == c_LEN_ONE);
                        end else begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_SEND: begin
                    // Beat registers only move on a handshake, so stalls hold them.
                    if (w_xfer) begin
                        if (r_remaining == c_LEN_ONE) begin
                            r_state     <= c_DONE;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_done      <= 1'b1;
                            r_remaining <= '0;
                        end else begin
                            r_data      <= r_data + c_STEP;
                            r_remaining <= r_remaining - c_LEN_ONE;
                            r_last      <= (r_remaining == c_LEN_TWO);
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_valid     <= 1'b0;
                    r_last      <= 1'b0;
                    r_done      <= 1'b0;
                    r_remaining <= '0;
                end
            endcase
        end
    end

`ifdef HD_BURST_TX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !bus.ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.cmd_ready    = (r_state == c_IDLE);
    assign bus.busy         = (r_state != c_IDLE);
    assign bus.valid_output = r_valid;
    assign bus.data_dest    = r_data;
    assign bus.last_output  = r_last;
    assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hd_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hd_burst_tx
//  Description : Directed bench for hd_burst_tx with a beat scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hd_burst_tx;

    localparam int c_DW  = 32;
    localparam int c_LW  = 8;
    localparam int c_STP = 1;

    typedef struct {
        logic [c_DW-1:0] data;
        logic            last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    beat_t q[$];
    logic            pend_done  = 1'b0;
    logic            prev_stall = 1'b0;
    logic [c_DW-1:0] prev_data  = '0;
    logic            prev_last  = 1'b0;

    hd_burst_tx_if #(.DATA_WIDTH(c_DW), .LEN_WIDTH(c_LW)) bus ();

    hd_burst_tx #(
        .DATA_WIDTH (c_DW),
        .LEN_WIDTH  (c_LW),
        .STEP       (c_STP)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {63'd0, bus.valid_output}, 64'd0);
            chk("rst_done",  {63'd0, bus.done}, 64'd0);
            q.delete();
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_pulse", {63'd0, bus.done}, {63'd0, pend_done});
            pend_done = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", {63'd0, bus.valid_output}, 64'd1);
                chk("hold_data",  {32'd0, bus.data_dest}, {32'd0, prev_data});
                chk("hold_last",  {63'd0, bus.last_output}, {63'd0, prev_last});
            end
            if (bus.valid_output && bus.ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_data", {32'd0, bus.data_dest}, {32'd0, e.data});
                    chk("beat_last", {63'd0, bus.last_output}, {63'd0, e.last});
                    if (e.last) pend_done = 1'b1;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && bus.cmd_len == '0) pend_done = 1'b1;
            prev_stall = bus.valid_output && !bus.ready;
            prev_data  = bus.data_dest;
            prev_last  = bus.last_output;
        end
    end

    task automatic send_cmd(input logic [c_DW-1:0] base, input int len,
                            input bit keep, output int waited);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = base;
        bus.cmd_len   = c_LW'(len);
        waited = 0;
        while (waited < 300) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        else begin
            for (int i = 0; i < len; i++) begin
                beat_t e;
                e.data = base + c_DW'(c_STP * i);
                e.last = (i == len - 1);
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q.size() != 0 || bus.busy) && n < 1000);
        chk("idle_timeout", {63'd0, (n < 1000)}, 64'd1);
    endtask

    initial begin
        int w;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.ready     = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_last", {63'd0, bus.last_output}, 64'd0);
        chk("reset_data", {32'd0, bus.data_dest}, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);

        // Basic burst, one-cycle accept-to-beat latency
        send_cmd(32'h10, 4, 1'b0, w);
        @(negedge clk);
        chk("first_beat_valid", {63'd0, bus.valid_output}, 64'd1);
        chk("first_beat_data",  {32'd0, bus.data_dest}, 64'h10);
        wait_idle();

        // Backpressure on the second beat
        send_cmd(32'h100, 3, 1'b0, w);
        @(posedge clk); #1 bus.ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, bus.valid_output}, 64'd1);
            chk("bp_data",  {32'd0, bus.data_dest}, 64'h101);
        end
        @(posedge clk); #1 bus.ready = 1'b1;
        wait_idle();
`ifdef HD_BURST_TX_STALL_CNT_EN
        chk("stall_cnt", {48'd0, bus.stall_cnt}, 64'd3);
`endif

        // Data wraps modulo 2^32
        send_cmd(32'hFFFF_FFFE, 3, 1'b0, w);
        wait_idle();

        // Empty burst
        send_cmd(32'h77, 0, 1'b0, w);
        @(negedge clk);
        chk("empty_done",      {63'd0, bus.done}, 64'd1);
        chk("empty_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        chk("empty_valid",     {63'd0, bus.valid_output}, 64'd0);
        @(negedge clk);
        chk("empty_back_idle", {63'd0, bus.cmd_ready}, 64'd1);

        // Back-to-back: second command waits out 4 beats + DONE
        send_cmd(32'h200, 4, 1'b1, w);
        send_cmd(32'h300, 2, 1'b0, w);
        chk("b2b_wait_cycles", 64'(w), 64'd4);
        wait_idle();

        // Maximum length with random backpressure
        send_cmd(32'h1000, 255, 1'b0, w);
        begin
            int n;
            n = 0;
            while ((q.size() != 0 || bus.busy) && n < 3000) begin
                @(posedge clk); #1 bus.ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                n++;
            end
            chk("max_len_timeout", {63'd0, (n < 3000)}, 64'd1);
        end
        @(posedge clk); #1 bus.ready = 1'b1;
        wait_idle();

        // Reset in the middle of a burst
        send_cmd(32'h500, 10, 1'b0, w);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, bus.valid_output}, 64'd0);
        chk("midrst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("midrst_data",  {32'd0, bus.data_dest}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        send_cmd(32'h55, 2, 1'b0, w);
        @(negedge clk);
        chk("post_rst_first", {32'd0, bus.data_dest}, 64'h55);
        wait_idle();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
